config_loader: RTL and testbench



---
 rtl/cfg_pkg.sv | 19 +
 rtl/config_loader_if.sv | 11 +
 rtl/cfg_onehot_decode.sv | 18 +
 rtl/config_loader.sv | 151 +++++++++++++++
 tb/tb_config_loader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// Shared types and constants for the serial configuration loader.
// CONFIG_LOADER_PARITY_EN adds one trailing even-parity bit to every frame.
package cfg_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, PARITY, COMMIT} state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int FCNT_W     = 16;

`ifdef CONFIG_LOADER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int FRAME_LEN = ADDR_W_DEF + DATA_W_DEF + PAR_BITS;

endpackage

// File: rtl/config_loader_if.sv
// Bit-serial configuration stream handshake between the stream source and the loader.
// Used the same way whether or not CONFIG_LOADER_PARITY_EN is defined.
interface config_loader_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;

  modport master (output cfg_start, cfg_valid, cfg_bit, input cfg_ready);
  modport slave  (input cfg_start, cfg_valid, cfg_bit, output cfg_ready);
endinterface

// File: rtl/cfg_onehot_decode.sv
// Frame address to per-tile one-hot strobe, with an out-of-range flag.
// Independent of CONFIG_LOADER_PARITY_EN.
module cfg_onehot_decode #(
  parameter int NUM_TILES = 16,
  parameter int ADDR_W    = 8
) (
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [NUM_TILES-1:0] onehot_o,
  output logic                 out_of_range_o
);

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_dec
    assign onehot_o[i] = (addr_i == ADDR_W'(i));
  end

  assign out_of_range_o = (32'(addr_i) >= 32'(NUM_TILES));

endmodule

// File: rtl/config_loader.sv
// Serial-to-parallel config loader: assembles addr+data frames, strobes one tile.
// CONFIG_LOADER_PARITY_EN inserts a PARITY state checking even parity over the frame.
module config_loader
  import cfg_pkg::*;
#(
  parameter int NUM_TILES = 16,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  config_loader_if.slave       cfg,
  output logic [DATA_W-1:0]    config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic [FCNT_W-1:0]    frame_count,
  output logic                 err_addr,
  output logic                 err_parity
);

  localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = $clog2(MAX_W);
  // Without parity the final data bit is taken straight from cfg_bit, so the
  // shift register only needs to hold the first DATA_W-1 bits.
`ifdef CONFIG_LOADER_PARITY_EN
  localparam int SH_W = DATA_W;
`else
  localparam int SH_W = DATA_W - 1;
`endif

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [SH_W-1:0]        data_q;
  logic [DATA_W-1:0]      cdata_q;
  logic [NUM_TILES-1:0]   en_q;
  logic [FCNT_W-1:0]      fcnt_q;
  logic                   err_addr_q;

  logic [NUM_TILES-1:0]   dec_onehot;
  logic                   dec_oor;
  logic                   shift_go;
  logic                   last_addr;
  logic                   last_data;
  logic                   commit_go;
  logic [DATA_W-1:0]      commit_word;

  cfg_onehot_decode #(.NUM_TILES(NUM_TILES), .ADDR_W(ADDR_W)) u_dec (
    .addr_i         (addr_q),
    .onehot_o       (dec_onehot),
    .out_of_range_o (dec_oor)
  );

  // A start pulse always wins over a data bit in the same cycle.
  assign shift_go  = cfg.cfg_valid && !cfg.cfg_start;
  assign last_addr = (cnt_q == CNT_W'(ADDR_W - 1));
  assign last_data = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef CONFIG_LOADER_PARITY_EN
  logic err_par_q;
  logic par_bad;
  assign par_bad     = ^{addr_q, data_q, cfg.cfg_bit};
  assign commit_go   = (state_q == PARITY) && shift_go && !par_bad;
  assign commit_word = data_q;
  assign err_parity  = err_par_q;
`else
  assign commit_go   = (state_q == DATA) && shift_go && last_data;
  assign commit_word = {data_q, cfg.cfg_bit};
  assign err_parity  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cdata_q    <= '0;
      en_q       <= '0;
      fcnt_q     <= '0;
      err_addr_q <= 1'b0;
`ifdef CONFIG_LOADER_PARITY_EN
      err_par_q  <= 1'b0;
`endif
    end else begin
      en_q <= '0;
      unique case (state_q)
        IDLE: if (cfg.cfg_start) begin
          state_q <= ADDR;
          cnt_q   <= '0;
        end
        COMMIT: state_q <= IDLE;
        default: begin
          if (cfg.cfg_start) begin
            state_q <= ADDR;
            cnt_q   <= '0;
          end else if (cfg.cfg_valid) begin
            case (state_q)
              ADDR: begin
                addr_q <= {addr_q[ADDR_W-2:0], cfg.cfg_bit};
                if (last_addr) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
                end else cnt_q <= cnt_q + CNT_W'(1);
              end
              DATA: begin
                data_q <= {data_q[SH_W-2:0], cfg.cfg_bit};
                if (last_data) begin
                  cnt_q <= '0;
`ifdef CONFIG_LOADER_PARITY_EN
                  state_q <= PARITY;
`else
                  state_q <= COMMIT;
`endif
                end else cnt_q <= cnt_q + CNT_W'(1);
              end
              PARITY: begin
`ifdef CONFIG_LOADER_PARITY_EN
                if (par_bad) begin
                  err_par_q <= 1'b1;
                  state_q   <= IDLE;
                end else state_q <= COMMIT;
`else
                state_q <= IDLE;
`endif
              end
              default: ;
            endcase
          end
        end
      endcase

      if (commit_go) begin
        if (dec_oor) err_addr_q <= 1'b1;
        else begin
          cdata_q <= commit_word;
          en_q    <= dec_onehot;
          if (fcnt_q != '1) fcnt_q <= fcnt_q + FCNT_W'(1);
        end
      end
    end
  end

  assign config_data   = cdata_q;
  assign config_en     = en_q;
  assign frame_count   = fcnt_q;
  assign err_addr      = err_addr_q;
  assign busy          = (state_q != IDLE);
  assign cfg.cfg_ready = (state_q != COMMIT);

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader; parity steps are built when
// CONFIG_LOADER_PARITY_EN is defined.
module tb_config_loader;
  import cfg_pkg::*;

  localparam int NT = 16;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  config_loader_if cif();

  logic [DW-1:0] config_data;
  logic [NT-1:0] config_en;
  logic          busy;
  logic [15:0]   frame_count;
  logic          err_addr;
  logic          err_parity;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CONFIG_LOADER_PARITY_EN
  logic bad_par;
`endif

  config_loader #(.NUM_TILES(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg         (cif),
    .config_data (config_data),
    .config_en   (config_en),
    .busy        (busy),
    .frame_count (frame_count),
    .err_addr    (err_addr),
    .err_parity  (err_parity)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    cif.cfg_valid = 1'b1;
    cif.cfg_bit   = b;
    tick();
  endtask

  task automatic start_pulse();
    cif.cfg_start = 1'b1;
    cif.cfg_valid = 1'b0;
    tick();
    cif.cfg_start = 1'b0;
  endtask

  // Full frame; optional valid gap of gap_len cycles before data bit gap_at.
  task automatic send_frame(input logic [7:0] a, input logic [31:0] d,
                            input int gap_at, input int gap_len);
    start_pulse();
    for (int i = AW - 1; i >= 0; i--) send_bit(a[i]);
    for (int i = DW - 1; i >= 0; i--) begin
      if (DW - 1 - i == gap_at) begin
        cif.cfg_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_en", 32'(config_en), 32'h0);
        end
      end
      if (i == 0) chk("pre_en", 32'(config_en), 32'h0);
      send_bit(d[i]);
    end
`ifdef CONFIG_LOADER_PARITY_EN
    chk("pre_par_en", 32'(config_en), 32'h0);
    send_bit((^{a, d}) ^ bad_par);
`endif
    cif.cfg_valid = 1'b0;
  endtask

  initial begin
    cif.cfg_start = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_bit   = 1'b0;
    reset_n       = 1'b0;
`ifdef CONFIG_LOADER_PARITY_EN
    bad_par = 1'b0;
`endif
    tick(); tick();
    reset_n = 1'b1;
    tick();

    chk("rst_en",    32'(config_en),   32'h0);
    chk("rst_data",  config_data,      32'h0);
    chk("rst_cnt",   32'(frame_count), 32'h0);
    chk("rst_eaddr", 32'(err_addr),    32'h0);
    chk("rst_epar",  32'(err_parity),  32'h0);
    chk("rst_busy",  32'(busy),        32'h0);
    chk("rst_ready", 32'(cif.cfg_ready), 32'h1);

    // Basic frame to tile 3
    send_frame(8'd3, 32'hDEADBEEF, -1, 0);
    chk("f1_en",    32'(config_en),   32'h0008);
    chk("f1_data",  config_data,      32'hDEADBEEF);
    chk("f1_cnt",   32'(frame_count), 32'h1);
    chk("f1_ready", 32'(cif.cfg_ready), 32'h0);
    chk("f1_busy",  32'(busy),        32'h1);
    tick();
    chk("f1_en_off",  32'(config_en), 32'h0);
    chk("f1_busy_off", 32'(busy),     32'h0);

    // Same frame with a 5-cycle valid gap mid-data
    send_frame(8'd3, 32'hDEADBEEF, 16, 5);
    chk("gap_en1",  32'(config_en),   32'h0008);
    chk("gap_data", config_data,      32'hDEADBEEF);
    chk("gap_cnt",  32'(frame_count), 32'h2);
    tick();
    chk("gap_en_off", 32'(config_en), 32'h0);

    // Out-of-range tile address
    send_frame(8'd20, 32'h12345678, -1, 0);
    chk("oor_en",   32'(config_en),   32'h0);
    chk("oor_err",  32'(err_addr),    32'h1);
    chk("oor_cnt",  32'(frame_count), 32'h2);
    chk("oor_data", config_data,      32'hDEADBEEF);
    tick();

    // Abort after 10 data bits, then a full frame
    start_pulse();
    for (int i = AW - 1; i >= 0; i--) send_bit(1'b0 ^ (i == 2) ^ (i == 0));
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    cif.cfg_valid = 1'b0;
    chk("ab_busy", 32'(busy), 32'h1);
    send_frame(8'd1, 32'h1, -1, 0);
    chk("ab_en",    32'(config_en),   32'h0002);
    chk("ab_cnt",   32'(frame_count), 32'h3);
    chk("ab_data",  config_data,      32'h1);
    chk("ab_eaddr", 32'(err_addr),    32'h1);
    tick();

    // Reset mid-DATA
    start_pulse();
    for (int i = AW - 1; i >= 0; i--) send_bit(i == 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cif.cfg_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rm_en",    32'(config_en),   32'h0);
    chk("rm_data",  config_data,      32'h0);
    chk("rm_cnt",   32'(frame_count), 32'h0);
    chk("rm_eaddr", 32'(err_addr),    32'h0);
    chk("rm_busy",  32'(busy),        32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    send_frame(8'd7, 32'hA5A5A5A5, -1, 0);
    chk("rr_en",   32'(config_en),   32'h0080);
    chk("rr_data", config_data,      32'hA5A5A5A5);
    chk("rr_cnt",  32'(frame_count), 32'h1);

    // Reset while the strobe is high drops it immediately
    reset_n = 1'b0;
    #1;
    chk("ad_en",  32'(config_en),   32'h0);
    chk("ad_cnt", 32'(frame_count), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

`ifdef CONFIG_LOADER_PARITY_EN
    bad_par = 1'b1;
    send_frame(8'd0, 32'h1, -1, 0);
    chk("pb_en",   32'(config_en),   32'h0);
    chk("pb_err",  32'(err_parity),  32'h1);
    chk("pb_busy", 32'(busy),        32'h0);
    chk("pb_cnt",  32'(frame_count), 32'h0);
    tick();
    bad_par = 1'b0;
    send_frame(8'd0, 32'h1, -1, 0);
    chk("pg_en",   32'(config_en),   32'h0001);
    chk("pg_cnt",  32'(frame_count), 32'h1);
    chk("pg_data", config_data,      32'h1);
    chk("pg_err",  32'(err_parity),  32'h1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
